// File: rtl/pe_sequencer.sv
// pe_sequencer: issues CLR/PASS, K MACs, optional RND and OUT to a PE for each
// accepted tile command, with operand-buffer addresses aligned to the PE's
// instruction register.
// Optional feature macro: PE_SEQ_PASS_EN (bias load via PASS instead of CLR).

`ifndef MODE_INT8
`define MODE_INT8  2'd0
`endif
`ifndef MODE_INT16
`define MODE_INT16 2'd1
`endif
`ifndef MODE_INT32
`define MODE_INT32 2'd2
`endif
`ifndef MODE_RSVD
`define MODE_RSVD  2'd3
`endif
`ifndef PE_RND_OPCODE
`define PE_RND_OPCODE 2'd1
`endif
`ifndef PE_CLR_VALUE
`define PE_CLR_VALUE  5'd1
`endif
`ifndef PE_MAC_VALUE
`define PE_MAC_VALUE  5'd2
`endif
`ifndef PE_PASS_VALUE
`define PE_PASS_VALUE 5'd3
`endif
`ifndef PE_OUT_VALUE
`define PE_OUT_VALUE  5'd4
`endif

package pe_sequencer_pkg;
  localparam int unsigned OPC_W  = 2;
  localparam int unsigned MODE_W = 2;
  localparam int unsigned VAL_W  = 5;

  // One PE instruction: opcode, lane mode, opcode-specific value.
  typedef struct packed {
    logic [OPC_W-1:0]  opcode;
    logic [MODE_W-1:0] mode;
    logic [VAL_W-1:0]  value;
  } pe_inst_t;
endpackage

module pe_sequencer
  import pe_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned K_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [MODE_W-1:0] cmd_mode,
  input  logic [K_W-1:0]    cmd_k,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic [VAL_W-1:0]  cmd_shift,
  input  logic              cmd_bias,
  input  logic              stall,
  output pe_inst_t          pe_inst,
  output logic              pe_inst_valid,
  output logic              buf_rd_en,
  output logic [ADDR_W-1:0] buf_rd_addr,
  output logic              busy,
  output logic              done,
  output logic              err
);

`ifdef PE_SEQ_PASS_EN
  localparam logic PASS_EN = 1'b1;
`else
  localparam logic PASS_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_MAC,
    S_RND,
    S_OUT,
    S_DRAIN,
    S_DONE,
    S_ERR
  } state_e;

  state_e              state_q;
  logic [MODE_W-1:0]   mode_q;
  logic [K_W-1:0]      k_q;
  logic [ADDR_W-1:0]   base_q;
  logic [VAL_W-1:0]    shift_q;
  logic                bias_q;
  logic [K_W-1:0]      cnt_q;
  logic [ADDR_W-1:0]   addr_q;

  pe_inst_t            inst_q;
  logic                inst_vld_q;
  logic                rd_en_q;
  logic [ADDR_W-1:0]   rd_addr_q;
  logic                busy_q;
  logic                done_q;
  logic                err_q;
  logic                ready_q;

  state_e              succ_state_d;
  logic [K_W-1:0]      succ_cnt_d;
  logic [ADDR_W-1:0]   succ_addr_d;
  state_e              issue_state_d;
  logic [K_W-1:0]      issue_cnt_d;
  logic [ADDR_W-1:0]   issue_addr_d;
  logic                acc_bias;

  assign acc_bias = cmd_bias & PASS_EN;

  // Instruction encoding for a given issue state.
  function automatic pe_inst_t build_inst(input state_e s, input logic [MODE_W-1:0] mode,
                                          input logic bias, input logic [VAL_W-1:0] shift);
    pe_inst_t r;
    r.opcode = '0;
    r.mode   = mode;
    r.value  = '0;
    case (s)
      S_CLR:   r.value = bias ? `PE_PASS_VALUE : `PE_CLR_VALUE;
      S_MAC:   r.value = `PE_MAC_VALUE;
      S_RND: begin
        r.opcode = `PE_RND_OPCODE;
        r.value  = shift;
      end
      S_OUT:   r.value = `PE_OUT_VALUE;
      default: r.value = '0;
    endcase
    return r;
  endfunction

  // Successor of the instruction currently in flight, with its MAC count and address.
  always_comb begin
    succ_state_d = S_DRAIN;
    succ_cnt_d   = cnt_q;
    succ_addr_d  = addr_q;
    case (state_q)
      S_CLR: begin
        if (k_q != '0) begin
          succ_state_d = S_MAC;
          succ_cnt_d   = k_q;
          succ_addr_d  = base_q + ADDR_W'(bias_q);
        end else if (shift_q != '0) begin
          succ_state_d = S_RND;
        end else begin
          succ_state_d = S_OUT;
        end
      end
      S_MAC: begin
        if (cnt_q > K_W'(1)) begin
          succ_state_d = S_MAC;
          succ_cnt_d   = cnt_q - K_W'(1);
          succ_addr_d  = addr_q + ADDR_W'(1);
        end else if (shift_q != '0) begin
          succ_state_d = S_RND;
        end else begin
          succ_state_d = S_OUT;
        end
      end
      S_RND:   succ_state_d = S_OUT;
      default: succ_state_d = S_DRAIN;
    endcase
  end

  // Next instruction to present: successor if the current one went out, else the held one.
  always_comb begin
    issue_state_d = state_q;
    issue_cnt_d   = cnt_q;
    issue_addr_d  = addr_q;
    if (inst_vld_q) begin
      issue_state_d = succ_state_d;
      issue_cnt_d   = succ_cnt_d;
      issue_addr_d  = succ_addr_d;
    end
  end

  // Sequencer FSM with registered PE, buffer and handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      mode_q     <= '0;
      k_q        <= '0;
      base_q     <= '0;
      shift_q    <= '0;
      bias_q     <= 1'b0;
      cnt_q      <= '0;
      addr_q     <= '0;
      inst_q     <= '0;
      inst_vld_q <= 1'b0;
      rd_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cmd_valid && ready_q) begin
            mode_q  <= cmd_mode;
            k_q     <= cmd_k;
            base_q  <= cmd_base;
            shift_q <= cmd_shift;
            bias_q  <= acc_bias;
            cnt_q   <= '0;
            addr_q  <= cmd_base;
            busy_q  <= 1'b1;
            ready_q <= 1'b0;
            if (cmd_mode == `MODE_RSVD) begin
              state_q <= S_ERR;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else begin
              state_q    <= S_CLR;
              inst_q     <= build_inst(S_CLR, cmd_mode, acc_bias, cmd_shift);
              inst_vld_q <= 1'b1;
              rd_en_q    <= acc_bias;
              rd_addr_q  <= cmd_base;
            end
          end
        end
        S_CLR, S_MAC, S_RND, S_OUT: begin
          if (inst_vld_q && (succ_state_d == S_DRAIN)) begin
            state_q    <= S_DRAIN;
            inst_vld_q <= 1'b0;
            rd_en_q    <= 1'b0;
          end else if (stall) begin
            state_q    <= issue_state_d;
            cnt_q      <= issue_cnt_d;
            addr_q     <= issue_addr_d;
            inst_vld_q <= 1'b0;
            rd_en_q    <= 1'b0;
          end else begin
            state_q    <= issue_state_d;
            cnt_q      <= issue_cnt_d;
            addr_q     <= issue_addr_d;
            inst_q     <= build_inst(issue_state_d, mode_q, bias_q, shift_q);
            inst_vld_q <= 1'b1;
            rd_en_q    <= (issue_state_d == S_MAC) || ((issue_state_d == S_CLR) && bias_q);
            rd_addr_q  <= (issue_state_d == S_CLR) ? base_q : issue_addr_d;
          end
        end
        S_DRAIN: begin
          state_q <= S_DONE;
          done_q  <= 1'b1;
        end
        S_DONE, S_ERR: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
        default: begin
          state_q    <= S_IDLE;
          inst_vld_q <= 1'b0;
          rd_en_q    <= 1'b0;
          busy_q     <= 1'b0;
          ready_q    <= 1'b1;
        end
      endcase
    end
  end

  assign cmd_ready     = ready_q;
  assign pe_inst       = inst_q;
  assign pe_inst_valid = inst_vld_q;
  assign buf_rd_en     = rd_en_q;
  assign buf_rd_addr   = rd_addr_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;

endmodule

// File: tb/tb_pe_sequencer.sv
// Directed bench for pe_sequencer: instruction stream, addresses, stall, reset, errors.
module tb_pe_sequencer;
  import pe_sequencer_pkg::*;

  localparam logic [1:0] M8  = 2'd0;
  localparam logic [1:0] M16 = 2'd1;
  localparam logic [1:0] M32 = 2'd2;
  localparam logic [1:0] OP0 = 2'd0;
  localparam logic [1:0] RND = 2'd1;
  localparam logic [4:0] V_CLR  = 5'd1;
  localparam logic [4:0] V_MAC  = 5'd2;
  localparam logic [4:0] V_PASS = 5'd3;
  localparam logic [4:0] V_OUT  = 5'd4;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_mode;
  logic [7:0] cmd_k;
  logic [7:0] cmd_base;
  logic [4:0] cmd_shift;
  logic       cmd_bias;
  logic       stall;
  pe_inst_t   pe_inst;
  logic       pe_inst_valid;
  logic       buf_rd_en;
  logic [7:0] buf_rd_addr;
  logic       busy;
  logic       done;
  logic       err;

  int checks = 0;
  int errors = 0;
  logic [1:0] cur_mode;

  always #5 clk = ~clk;

  pe_sequencer #(.ADDR_W(8), .K_W(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
    .cmd_k(cmd_k), .cmd_base(cmd_base), .cmd_shift(cmd_shift), .cmd_bias(cmd_bias),
    .stall(stall), .pe_inst(pe_inst), .pe_inst_valid(pe_inst_valid),
    .buf_rd_en(buf_rd_en), .buf_rd_addr(buf_rd_addr),
    .busy(busy), .done(done), .err(err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check one busy cycle of a tile.
  task automatic cyc(input string tag, input logic v, input logic [1:0] opc,
                     input logic [4:0] val, input logic rden, input logic [7:0] addr,
                     input logic dn);
    chk({tag, ".vld"}, 32'(pe_inst_valid), 32'(v));
    if (v) begin
      chk({tag, ".opc"},  32'(pe_inst.opcode), 32'(opc));
      chk({tag, ".val"},  32'(pe_inst.value),  32'(val));
      chk({tag, ".mode"}, 32'(pe_inst.mode),   32'(cur_mode));
    end
    chk({tag, ".rden"}, 32'(buf_rd_en), 32'(rden));
    if (rden) chk({tag, ".addr"}, 32'(buf_rd_addr), 32'(addr));
    chk({tag, ".done"},  32'(done), 32'(dn));
    chk({tag, ".err"},   32'(err), 32'd0);
    chk({tag, ".busy"},  32'(busy), 32'd1);
    chk({tag, ".ready"}, 32'(cmd_ready), 32'd0);
  endtask

  task automatic idle(input string tag);
    chk({tag, ".ready"}, 32'(cmd_ready), 32'd1);
    chk({tag, ".busy"},  32'(busy), 32'd0);
    chk({tag, ".vld"},   32'(pe_inst_valid), 32'd0);
    chk({tag, ".done"},  32'(done), 32'd0);
    chk({tag, ".err"},   32'(err), 32'd0);
  endtask

  // Present a command for one edge, then scramble the fields to prove they were latched.
  task automatic send(input logic [1:0] m, input logic [7:0] k, input logic [7:0] b,
                      input logic [4:0] sh, input logic bias);
    cmd_mode = m; cmd_k = k; cmd_base = b; cmd_shift = sh; cmd_bias = bias;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    cmd_mode = 2'd3; cmd_k = 8'hFF; cmd_base = 8'hA5; cmd_shift = 5'h1F; cmd_bias = ~bias;
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b1; cmd_mode = M8; cmd_k = 8'd3; cmd_base = 8'h10;
    cmd_shift = 5'd0; cmd_bias = 1'b0; stall = 1'b0; cur_mode = M8;
    step(); step();
    idle("rst");
    chk("rst.inst", 32'(pe_inst), 32'd0);
    chk("rst.rden", 32'(buf_rd_en), 32'd0);
    rst = 1'b0; cmd_valid = 1'b0;
    step();
    idle("post_rst");

    // INT8 k=3 base=0x10 shift=0: done at T+7
    cur_mode = M8;
    send(M8, 8'd3, 8'h10, 5'd0, 1'b0);
    cyc("t1.clr", 1, OP0, V_CLR, 0, 8'h00, 0); step();
    cyc("t1.mac0", 1, OP0, V_MAC, 1, 8'h10, 0); step();
    cyc("t1.mac1", 1, OP0, V_MAC, 1, 8'h11, 0); step();
    cyc("t1.mac2", 1, OP0, V_MAC, 1, 8'h12, 0); step();
    cyc("t1.out", 1, OP0, V_OUT, 0, 8'h00, 0); step();
    cyc("t1.drain", 0, OP0, 5'd0, 0, 8'h00, 0); step();
    cyc("t1.done", 0, OP0, 5'd0, 0, 8'h00, 1); step();
    idle("t1.idle");

    // INT16 k=2 shift=4: RND inserted, done at T+7
    cur_mode = M16;
    send(M16, 8'd2, 8'h40, 5'd4, 1'b0);
    cyc("t2.clr", 1, OP0, V_CLR, 0, 8'h00, 0); step();
    cyc("t2.mac0", 1, OP0, V_MAC, 1, 8'h40, 0); step();
    cyc("t2.mac1", 1, OP0, V_MAC, 1, 8'h41, 0); step();
    cyc("t2.rnd", 1, RND, 5'd4, 0, 8'h00, 0); step();
    cyc("t2.out", 1, OP0, V_OUT, 0, 8'h00, 0); step();
    cyc("t2.drain", 0, OP0, 5'd0, 0, 8'h00, 0); step();
    cyc("t2.done", 0, OP0, 5'd0, 0, 8'h00, 1); step();
    idle("t2.idle");

    // INT32 k=0 shift=0: CLR, OUT, done at T+4
    cur_mode = M32;
    send(M32, 8'd0, 8'h55, 5'd0, 1'b0);
    cyc("t3.clr", 1, OP0, V_CLR, 0, 8'h00, 0); step();
    cyc("t3.out", 1, OP0, V_OUT, 0, 8'h00, 0); step();
    cyc("t3.drain", 0, OP0, 5'd0, 0, 8'h00, 0); step();
    cyc("t3.done", 0, OP0, 5'd0, 1'b0, 8'h00, 1); step();
    idle("t3.idle");

    // INT8 k=4 base=0xFE, 3-cycle stall after the 2nd MAC: wrap, done at T+11
    cur_mode = M8;
    send(M8, 8'd4, 8'hFE, 5'd0, 1'b0);
    cyc("t4.clr", 1, OP0, V_CLR, 0, 8'h00, 0); step();
    cyc("t4.mac0", 1, OP0, V_MAC, 1, 8'hFE, 0); step();
    cyc("t4.mac1", 1, OP0, V_MAC, 1, 8'hFF, 0);
    stall = 1'b1; step();
    cyc("t4.st0", 0, OP0, 5'd0, 0, 8'h00, 0); step();
    cyc("t4.st1", 0, OP0, 5'd0, 0, 8'h00, 0); step();
    cyc("t4.st2", 0, OP0, 5'd0, 0, 8'h00, 0);
    stall = 1'b0; step();
    cyc("t4.mac2", 1, OP0, V_MAC, 1, 8'h00, 0); step();
    cyc("t4.mac3", 1, OP0, V_MAC, 1, 8'h01, 0); step();
    cyc("t4.out", 1, OP0, V_OUT, 0, 8'h00, 0); step();
    cyc("t4.drain", 0, OP0, 5'd0, 0, 8'h00, 0); step();
    cyc("t4.done", 0, OP0, 5'd0, 0, 8'h00, 1); step();
    idle("t4.idle");

    // Reserved mode: err and done at T+1, no instruction
    send(2'b11, 8'd2, 8'h00, 5'd0, 1'b0);
    chk("t5.done", 32'(done), 32'd1);
    chk("t5.err",  32'(err), 32'd1);
    chk("t5.vld",  32'(pe_inst_valid), 32'd0);
    chk("t5.busy", 32'(busy), 32'd1);
    step();
    idle("t5.idle");

    // Reset during MAC: IDLE next cycle, nothing more issued
    cur_mode = M16;
    send(M16, 8'd5, 8'h30, 5'd0, 1'b0);
    cyc("t6.clr", 1, OP0, V_CLR, 0, 8'h00, 0); step();
    cyc("t6.mac0", 1, OP0, V_MAC, 1, 8'h30, 0);
    rst = 1'b1; step();
    rst = 1'b0;
    idle("t6.rst");
    for (int i = 0; i < 6; i++) begin
      step();
      chk("t6.quiet", 32'(pe_inst_valid), 32'd0);
    end
    idle("t6.idle");

    // cmd_bias=1 base=0x20 k=2: PASS when the feature is built in, else ignored
    cur_mode = M8;
    send(M8, 8'd2, 8'h20, 5'd0, 1'b1);
`ifdef PE_SEQ_PASS_EN
    cyc("t7.pass", 1, OP0, V_PASS, 1, 8'h20, 0); step();
    cyc("t7.mac0", 1, OP0, V_MAC, 1, 8'h21, 0); step();
    cyc("t7.mac1", 1, OP0, V_MAC, 1, 8'h22, 0); step();
`else
    cyc("t7.clr", 1, OP0, V_CLR, 0, 8'h00, 0); step();
    cyc("t7.mac0", 1, OP0, V_MAC, 1, 8'h20, 0); step();
    cyc("t7.mac1", 1, OP0, V_MAC, 1, 8'h21, 0); step();
`endif
    cyc("t7.out", 1, OP0, V_OUT, 0, 8'h00, 0); step();
    cyc("t7.drain", 0, OP0, 5'd0, 0, 8'h00, 0); step();
    cyc("t7.done", 0, OP0, 5'd0, 0, 8'h00, 1); step();
    idle("t7.idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pe_sequencer.md
Name: pe_sequencer

Overview:
- Issues the per-tile instruction stream to one processing element (or a lock-step PE column), one command at a time.
- For each accepted tile command it emits CLR (or PASS), K MAC steps, an optional RND, then OUT.
- Generates operand-buffer read addresses aligned to the PE's one-cycle instruction register.
- Signals completion once the PE's vector_output holds the tile result.

Parameters:
- ADDR_W, 8: operand buffer address width.
- K_W, 8: width of the MAC count field.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cmd_valid  in  1  tile command valid
- cmd_ready  out  1  high only in IDLE
- cmd_mode  in  2  `MODE_INT8 / `MODE_INT16 / `MODE_INT32
- cmd_k  in  K_W  number of MAC steps
- cmd_base  in  ADDR_W  first operand address
- cmd_shift  in  pe_inst_t value width  RND shift amount; 0 means skip RND
- cmd_bias  in  1  load bias via PASS instead of CLR (optional feature only)
- stall  in  1  hold issue (buffer or array not ready)
- pe_inst  out  pe_inst_t  instruction to PE
- pe_inst_valid  out  1  instruction valid
- buf_rd_en  out  1  operand buffer read enable
- buf_rd_addr  out  ADDR_W  operand buffer address
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse: PE vector_output valid
- err  out  1  one-cycle pulse with done for a rejected command

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset: the cycle after rst=1, state=IDLE and all outputs are 0 (pe_inst='0), except cmd_ready=1. Reset mid-operation abandons the tile immediately and issues no further instructions.
- Accept: handshake at edge T when cmd_valid && cmd_ready. All cmd_* fields are latched; they need not be held afterwards.
- States and transitions:
  - IDLE: on accept -> CLR. If the mode is reserved -> ERR.
  - CLR: issues opcode 0, value `PE_CLR_VALUE, latched mode. Next: MAC if k>0; else RND if shift!=0; else OUT.
  - MAC: issues opcode 0, value `PE_MAC_VALUE with buf_rd_en=1 and buf_rd_addr=base+i, for i=0..k-1. Next after i=k-1: RND or OUT.
  - RND: issues opcode `PE_RND_OPCODE, value=shift, one cycle. Next: OUT.
  - OUT: issues opcode 0, value `PE_OUT_VALUE, one cycle. Next: DRAIN.
  - DRAIN: 1 cycle, nothing issued. Next: DONE.
  - DONE: done=1 for one cycle. Next: IDLE, with cmd_ready=1 in the following cycle.
  - ERR: done=1 and err=1 for one cycle. No PE instruction is issued. Next: IDLE.
- Timing: registered outputs; the first instruction (CLR) is valid in cycle T+1.
  - Unstalled tile: done at cycle T+1 + 1 + k + (shift!=0) + 2.
  - Example: k=4, shift=0 gives done at T+8.
- Alignment: the buffer has 1-cycle read latency and the PE registers pe_inst for 1 cycle, so the address is issued in the same cycle as its MAC.
- Stall: sampled every cycle in CLR/MAC/RND/OUT.
  - While stall=1: pe_inst_valid=0, buf_rd_en=0; state, MAC index and address hold.
  - pe_inst fields may hold their last value.
  - DRAIN and DONE ignore stall.
- Address wraps modulo 2^ADDR_W (base=0xFE, k=4 -> FE, FF, 00, 01).
- pe_inst.mode equals the latched cmd_mode for every instruction of the tile.
- k is unsigned; the full range 0..2^K_W-1 is valid.
- Simultaneous rst and cmd_valid: reset wins; the command is not accepted.

Optional Feature:
- Macro: PE_SEQ_PASS_EN
- Defined: if cmd_bias=1, the CLR state instead issues opcode 0, value `PE_PASS_VALUE with buf_rd_en=1 and buf_rd_addr=base. The MAC sequence then starts at base+1 and still runs k steps. Latency is unchanged.
- Undefined: cmd_bias is ignored. CLR is always issued and MACs start at base.

Test Plan:
- Reset with rst=1 for 2 cycles, then cmd INT8 k=3 base=0x10 shift=0 -> in order: CLR, MAC@10, MAC@11, MAC@12, OUT; done at T+7; busy=1 from T+1 to T+7.
- INT16 k=2 shift=4 -> CLR, MAC, MAC, RND(value=4), OUT; done at T+7; the PE output equals (sum of products)>>>4 per 32-bit lane.
- INT32 k=0 shift=0 -> CLR, OUT; done at T+4; vector_output=0.
- INT8 k=4 base=0xFE with stall=1 during the 2nd MAC for 3 cycles -> addresses FE, FF, 00, 01 each issued exactly once; done delayed by 3 cycles.
- Reserved mode=2'b11 -> err and done together at T+1; pe_inst_valid stays 0. Also: rst=1 during MAC -> IDLE next cycle and no OUT is issued.
- PE_SEQ_PASS_EN, cmd_bias=1, base=0x20, k=2 -> PASS@20, MAC@21, MAC@22, OUT; the result includes the bias.
